fetch_skid_buffer: RTL



---
 rtl/fetch_skid_buffer_if.sv | 27 ++
 rtl/fetch_skid_buffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fetch_skid_buffer_if.sv
// Fetch-to-decode handshake bundle for the two-entry skid buffer.
// The slave modport is the buffer's view; the master modport is the fetch/decode side.
interface fetch_skid_buffer_if #(
    parameter int INSTR_WIDTH = 16,
    parameter int PC_WIDTH    = 16
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic [PC_WIDTH-1:0]    in_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [PC_WIDTH-1:0]    out_pc;
    logic [1:0]             occupancy;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, occupancy
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, occupancy
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// Two-entry elastic buffer between fetch and decode: in_ready depends only on
// registered state, so decode stall logic never reaches fetch combinationally.
module fetch_skid_buffer #(
    parameter int INSTR_WIDTH = 16,
    parameter int PC_WIDTH    = 16
) (
    input logic               clk,
    input logic               rst,
    fetch_skid_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;

    logic [INSTR_WIDTH-1:0] main_instr_r;
    logic [PC_WIDTH-1:0]    main_pc_r;
    logic [INSTR_WIDTH-1:0] skid_instr_r;
    logic [PC_WIDTH-1:0]    skid_pc_r;

    logic                   main_valid_s;
    logic                   skid_valid_s;
    logic                   in_ready_s;
    logic [1:0]             occupancy_s;
    logic                   accept_s;
    logic                   fire_s;
    logic                   load_main_in_s;
    logic                   load_main_skid_s;
    logic                   load_skid_s;

    // State register; the encoding equals the number of held entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; flush takes priority over every handshake event.
    always_comb begin
        state_next_s = state_r;
        if (bus.flush) begin
            state_next_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) state_next_s = ONE;
                    else          state_next_s = EMPTY;
                end
                ONE: begin
                    if (accept_s && !fire_s)      state_next_s = TWO;
                    else if (fire_s && !accept_s) state_next_s = EMPTY;
                    else                          state_next_s = ONE;
                end
                TWO: begin
                    if (fire_s) state_next_s = ONE;
                    else        state_next_s = TWO;
                end
                default: state_next_s = EMPTY;
            endcase
        end
    end

    // Status outputs and one load enable per data register.
    always_comb begin
        main_valid_s     = 1'b0;
        skid_valid_s     = 1'b0;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            EMPTY: begin
                main_valid_s = 1'b0;
                skid_valid_s = 1'b0;
            end
            ONE: begin
                main_valid_s = 1'b1;
                skid_valid_s = 1'b0;
            end
            TWO: begin
                main_valid_s = 1'b1;
                skid_valid_s = 1'b1;
            end
            default: begin
                main_valid_s = 1'b0;
                skid_valid_s = 1'b0;
            end
        endcase
        in_ready_s  = ~skid_valid_s;
        occupancy_s = {1'b0, main_valid_s} + {1'b0, skid_valid_s};
        accept_s    = bus.in_valid & in_ready_s;
        fire_s      = main_valid_s & bus.out_ready;
        if (bus.flush) begin
            load_main_in_s   = 1'b0;
            load_main_skid_s = 1'b0;
            load_skid_s      = 1'b0;
        end else begin
            load_main_in_s   = accept_s && ((state_r == EMPTY) || ((state_r == ONE) && fire_s));
            load_skid_s      = accept_s && (state_r == ONE) && !fire_s;
            load_main_skid_s = fire_s && (state_r == TWO);
        end
    end

    // Head entry data; holds its last value while the buffer is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_instr_r <= {INSTR_WIDTH{1'b0}};
            main_pc_r    <= {PC_WIDTH{1'b0}};
        end else if (load_main_in_s) begin
            main_instr_r <= bus.in_instr;
            main_pc_r    <= bus.in_pc;
        end else if (load_main_skid_s) begin
            main_instr_r <= skid_instr_r;
            main_pc_r    <= skid_pc_r;
        end
    end

    // Second entry data, captured only when decode stalls with one entry held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_instr_r <= {INSTR_WIDTH{1'b0}};
            skid_pc_r    <= {PC_WIDTH{1'b0}};
        end else if (load_skid_s) begin
            skid_instr_r <= bus.in_instr;
            skid_pc_r    <= bus.in_pc;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = main_valid_s;
    assign bus.out_instr = main_instr_r;
    assign bus.out_pc    = main_pc_r;
    assign bus.occupancy = occupancy_s;

endmodule
